// File: rtl/noc_arb_requester.sv
// noc_arb_requester: requester-side FIFO port buffer for one NoC arbiter input; optional starvation monitor under NOC_REQ_STARVE_MON_EN
module noc_arb_requester #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int PTR_W        = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  request,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PTR_W:0]        count,
    output logic                  spurious_grant,
    output logic                  starve
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic push, pop;
    assign in_ready = count != (PTR_W+1)'(DEPTH);
    assign request  = count != '0;
    assign push     = in_valid && in_ready;
    assign pop      = grant && request;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            spurious_grant <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_data <= mem[rd_ptr];
            end
            count          <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
            out_valid      <= pop;
            spurious_grant <= grant && !request;
        end
    end
`ifdef NOC_REQ_STARVE_MON_EN
    logic [7:0] starve_cnt, starve_nxt;
    always_comb starve_nxt = (!request || grant) ? 8'd0 : (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            starve     <= starve_nxt >= 8'(STARVE_LIMIT);
        end
    end
`else
    assign starve = 1'b0;
`endif
endmodule

// File: tb/tb_noc_arb_requester.sv
// tb_noc_arb_requester: directed vector table, starvation sequence and randomized queue-model check
module tb_noc_arb_requester;
    localparam int DW = 32, DEPTH = 4, PW = 2, LIM = 16;
`ifdef NOC_REQ_STARVE_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif
    logic clk = 1'b0, rst, in_valid, grant, in_ready, request, out_valid, spurious_grant, starve;
    logic [DW-1:0] in_data, out_data;
    logic [PW:0] count;
    int checks = 0, failures = 0;

    noc_arb_requester #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .request(request), .grant(grant), .out_valid(out_valid), .out_data(out_data),
        .count(count), .spurious_grant(spurious_grant), .starve(starve)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, v;
        logic [31:0] d;
        logic g;
        int cnt;
        logic ov;
        logic [31:0] od;
        logic sp;
    } vec_t;
    vec_t tv[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic g);
        rst = r; in_valid = v; in_data = d; grant = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input int cnt, input logic ov, input logic [31:0] od, input logic sp, input logic st);
        chk("count", 32'(count), 32'(cnt));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("out_data", out_data, od);
        chk("spurious_grant", 32'(spurious_grant), 32'(sp));
        chk("in_ready", 32'(in_ready), 32'(cnt != DEPTH));
        chk("request", 32'(request), 32'(cnt != 0));
        chk("starve", 32'(starve), 32'(st));
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] od;
        int st, sz;
        logic r, v, g, ov, sp;
        logic [31:0] d;
        tv[0]  = '{1, 0, 0, 0,    0, 0, 0,     0};
        tv[1]  = '{0, 0, 0, 0,    0, 0, 0,     0};
        tv[2]  = '{0, 1, 'hA1, 0, 1, 0, 0,     0};
        tv[3]  = '{0, 1, 'hA2, 0, 2, 0, 0,     0};
        tv[4]  = '{0, 1, 'hA3, 0, 3, 0, 0,     0};
        tv[5]  = '{0, 0, 0, 1,    2, 1, 'hA1,  0};
        tv[6]  = '{0, 0, 0, 1,    1, 1, 'hA2,  0};
        tv[7]  = '{0, 0, 0, 1,    0, 1, 'hA3,  0};
        tv[8]  = '{0, 0, 0, 1,    0, 0, 'hA3,  1};
        tv[9]  = '{0, 0, 0, 0,    0, 0, 'hA3,  0};
        tv[10] = '{0, 1, 'hB1, 0, 1, 0, 'hA3,  0};
        tv[11] = '{0, 1, 'hB2, 0, 2, 0, 'hA3,  0};
        tv[12] = '{0, 1, 'hB3, 0, 3, 0, 'hA3,  0};
        tv[13] = '{0, 1, 'hB4, 0, 4, 0, 'hA3,  0};
        tv[14] = '{0, 1, 'hB5, 0, 4, 0, 'hA3,  0};
        tv[15] = '{0, 1, 'hB5, 1, 3, 1, 'hB1,  0};
        tv[16] = '{0, 1, 'hB5, 0, 4, 0, 'hB1,  0};
        tv[17] = '{0, 0, 0, 1,    3, 1, 'hB2,  0};
        tv[18] = '{0, 1, 'hC1, 1, 3, 1, 'hB3,  0};
        tv[19] = '{0, 0, 0, 1,    2, 1, 'hB4,  0};
        tv[20] = '{0, 1, 'hC2, 1, 2, 1, 'hB5,  0};
        tv[21] = '{0, 0, 0, 1,    1, 1, 'hC1,  0};
        tv[22] = '{0, 0, 0, 1,    0, 1, 'hC2,  0};
        tv[23] = '{0, 0, 0, 0,    0, 0, 'hC2,  0};
        tv[24] = '{0, 1, 'hD1, 0, 1, 0, 'hC2,  0};
        tv[25] = '{0, 1, 'hD2, 0, 2, 0, 'hC2,  0};
        tv[26] = '{1, 1, 'hD3, 0, 0, 0, 0,     0};
        tv[27] = '{0, 0, 0, 1,    0, 0, 0,     1};
        tv[28] = '{0, 1, 'hE1, 0, 1, 0, 0,     0};
        tv[29] = '{0, 0, 0, 1,    0, 1, 'hE1,  0};
        rst = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(tv[i].r, tv[i].v, tv[i].d, tv[i].g);
            chk_all(tv[i].cnt, tv[i].ov, tv[i].od, tv[i].sp, 1'b0);
        end

        // starvation: one queued packet stalled, then granted, then reset mid-stall
        step(0, 1, 32'h55, 0);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 0);
            chk_all(1, 0, 'hE1, 0, MON && k >= LIM);
        end
        step(0, 0, 0, 1);
        chk_all(0, 1, 32'h55, 0, 1'b0);
        step(0, 1, 32'h66, 0);
        for (int k = 1; k <= 18; k++) step(0, 0, 0, 0);
        chk_all(1, 0, 32'h55, 0, MON);
        step(1, 0, 0, 0);
        chk_all(0, 0, 0, 0, 1'b0);

        od = '0; st = 0;
        for (int n = 0; n < 2000; n++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 99) < 55);
            g = ($urandom_range(0, 99) < ((n / 250) % 2 ? 15 : 50));
            d = $urandom;
            sz = q.size();
            if (r) begin
                q.delete(); od = '0; st = 0; ov = 0; sp = 0;
            end else begin
                sp = g && sz == 0;
                ov = g && sz > 0;
                if (ov) od = q.pop_front();
                st = (sz == 0 || g) ? 0 : (st < 255 ? st + 1 : 255);
                if (v && sz < DEPTH) q.push_back(d);
            end
            step(r, v, d, g);
            chk_all(q.size(), ov, od, sp, MON && st >= LIM);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
